data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter: ADDR_W, 8, memory address width.
REQ-002 SHALL have parameter: DATA_W, 16, memory data width.
REQ-003 SHALL have parameter: STARVE_LIMIT, 4, consecutive contested port-A grants before port B is forced.
REQ-004 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports: a_req, a_we, a_lock  in  1 each  port A (pipeline) request, write select, lock.
REQ-007 SHALL have ports: a_addr  in  ADDR_W; a_wdata  in  DATA_W  port A address and write data.
REQ-008 SHALL have ports: a_gnt  out  1; a_rvalid  out  1; a_rdata  out  DATA_W  port A grant and read return.
REQ-009 SHALL have ports b_req, b_we, b_lock, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata, identical to port A, for port B (loader/debug).
REQ-010 SHALL have ports: mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_w_en  out  1; mem_rdata  in  DATA_W  to the data memory.

Function
- REQ-011 SHALL complete a transfer in any cycle where x_req && x_gnt; x_gnt is combinational from the current requests and registered state.
- REQ-012 SHALL assert at most one of a_gnt, b_gnt per cycle; neither without the matching req.
- REQ-013 SHALL drive mem_addr/mem_wdata from the granted port, mem_w_en = granted x_we; with no grant: mem_w_en=0, mem_addr/mem_wdata=0.
- REQ-014 SHALL, on a granted read, register mem_rdata into x_rdata at the closing edge and pulse x_rvalid high for exactly the next cycle (read latency 1); granted writes never assert rvalid.
- REQ-015 SHALL hold x_rdata until the next read return on that port.
- REQ-016 SHALL implement FSM OPEN, LOCK_A, LOCK_B; OPEN: arbitrate per REQ-017.
- REQ-017 In OPEN with only one req: grant it; both req: grant A unless the starvation rule (REQ-021) selects B.
- REQ-018 SHALL go OPEN->LOCK_x when a transfer completes on x with x_lock=1; LOCK_x->OPEN when a transfer completes on x with x_lock=0.
- REQ-019 In LOCK_x SHALL grant only port x; the other port's req is held off regardless of priority.
- REQ-020 SHALL allow back-to-back grants to the same port on consecutive cycles when its req stays high.
- REQ-021 starve_cnt (3 bits): +1 on each A grant while b_req=1 in OPEN, saturating at STARVE_LIMIT; cleared on any B grant or any cycle with b_req=0; when starve_cnt==STARVE_LIMIT and both req in OPEN, grant B.

Reset
- REQ-022 While rst=1 at a rising edge: FSM -> OPEN, starve_cnt -> 0, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0.
- REQ-023 While rst=1, a_gnt=b_gnt=0 and mem_w_en=0 combinationally, so no write reaches memory mid-reset, including from LOCK states.
- REQ-024 A read granted in the cycle before rst rises SHALL NOT produce rvalid after reset.

Configuration
- REQ-025 Macro DATA_MEM_ARB_STARVE_GUARD_EN: defined -> REQ-021 in force; undefined -> starve_cnt absent, strict A priority in OPEN (B granted only when a_req=0 or in LOCK_B).

Verification
- REQ-026 A read addr 0x05 (mem holds 0x0004), b_req=0 -> a_gnt same cycle, a_rvalid next cycle, a_rdata=0x0004.
- REQ-027 B write addr 0x0A data 0xFFFC then B read 0x0A -> two consecutive b_gnt, mem_w_en=1 first cycle only, b_rdata=0xFFFC.
- REQ-028 a_req and b_req held high 10 cycles (guard enabled) -> grants A,A,A,A,B,A,A,A,A,B; guard disabled -> A all 10 cycles.
- REQ-029 B read 0x00 with b_lock=1, then a_req high while B writes 0x00 with b_lock=0 -> A blocked two cycles, a_gnt in third cycle, FSM back to OPEN.
- REQ-030 A enters LOCK_A, rst pulsed one cycle with a_req/a_we high -> mem_w_en=0 during reset, FSM OPEN afterward, b_req granted next cycle.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Two-port data memory arbiter with lock-based atomic sequences and 1-cycle read return.
// Optional B-port starvation guard enabled by defining DATA_MEM_ARB_STARVE_GUARD_EN.
module data_mem_arbiter #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  // Port A (pipeline)
  input  logic              a_req,
  input  logic              a_we,
  input  logic              a_lock,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  // Port B (loader/debug)
  input  logic              b_req,
  input  logic              b_we,
  input  logic              b_lock,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  // Data memory
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_w_en,
  input  logic [DATA_W-1:0] mem_rdata
);

  // The starvation counter is 3 bits wide, so the limit must fit in it.
  if (STARVE_LIMIT == 0 || STARVE_LIMIT > 7) begin : g_bad_limit
    $error("STARVE_LIMIT must be in 1..7");
  end

  typedef enum logic [1:0] {
    StOpen,
    StLockA,
    StLockB
  } state_e;

  state_e state_q, state_d;

  logic              a_rvalid_q, b_rvalid_q;
  logic [DATA_W-1:0] a_rdata_q, b_rdata_q;
  logic              a_xfer, b_xfer;

`ifdef DATA_MEM_ARB_STARVE_GUARD_EN
  logic [2:0] starve_q, starve_d;
  logic       starve_hit;

  assign starve_hit = (starve_q == 3'(STARVE_LIMIT));
`endif

  // Grants are purely combinational from requests and registered state; reset kills them.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!rst) begin
      case (state_q)
        StOpen: begin
`ifdef DATA_MEM_ARB_STARVE_GUARD_EN
          if (a_req && b_req) begin
            b_gnt = starve_hit;
            a_gnt = !starve_hit;
          end else begin
            a_gnt = a_req;
            b_gnt = b_req;
          end
`else
          a_gnt = a_req;
          b_gnt = b_req && !a_req;
`endif
        end
        StLockA: a_gnt = a_req;
        StLockB: b_gnt = b_req;
        default: begin
          a_gnt = 1'b0;
          b_gnt = 1'b0;
        end
      endcase
    end
  end

  assign a_xfer = a_req && a_gnt;
  assign b_xfer = b_req && b_gnt;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StOpen: begin
        if (a_xfer && a_lock) begin
          state_d = StLockA;
        end else if (b_xfer && b_lock) begin
          state_d = StLockB;
        end
      end
      StLockA: if (a_xfer && !a_lock) state_d = StOpen;
      StLockB: if (b_xfer && !b_lock) state_d = StOpen;
      default: state_d = StOpen;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StOpen;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef DATA_MEM_ARB_STARVE_GUARD_EN
  always_comb begin
    starve_d = starve_q;
    if (!b_req || b_gnt) begin
      starve_d = 3'd0;
    end else if (a_gnt && (state_q == StOpen) && !starve_hit) begin
      starve_d = starve_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= 3'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_w_en  = 1'b0;
    if (a_gnt) begin
      mem_addr  = a_addr;
      mem_wdata = a_wdata;
      mem_w_en  = a_we;
    end else if (b_gnt) begin
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
      mem_w_en  = b_we;
    end
  end

  // Read return: capture memory data at the edge closing the granted read.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      a_rvalid_q <= a_xfer && !a_we;
      b_rvalid_q <= b_xfer && !b_we;
      if (a_xfer && !a_we) a_rdata_q <= mem_rdata;
      if (b_xfer && !b_we) b_rdata_q <= mem_rdata;
    end
  end

  // A return pending across a reset edge must never surface.
  assign a_rvalid = a_rvalid_q && !rst;
  assign b_rvalid = b_rvalid_q && !rst;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;

  a_gnt_onehot: assert property (@(posedge clk) !(a_gnt && b_gnt));
  gnt_needs_req: assert property (@(posedge clk) (!a_gnt || a_req) && (!b_gnt || b_req));

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: grants checked per cycle, read returns via scoreboard.
module tb_data_mem_arbiter;

`ifdef DATA_MEM_ARB_STARVE_GUARD_EN
  localparam bit Guard = 1'b1;
`else
  localparam bit Guard = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_we, a_lock, b_req, b_we, b_lock;
  logic [7:0]  a_addr, b_addr, mem_addr;
  logic [15:0] a_wdata, b_wdata, mem_wdata, mem_rdata, a_rdata, b_rdata;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid, mem_w_en;

  int checks = 0;
  int errors = 0;

  logic [15:0] a_exp[$];
  logic [15:0] b_exp[$];

  logic [15:0] mem [256];
  bit          loaded = 1'b0;

  always #5 clk = ~clk;

  data_mem_arbiter #(
    .ADDR_W      (8),
    .DATA_W      (16),
    .STARVE_LIMIT(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .a_req    (a_req),
    .a_we     (a_we),
    .a_lock   (a_lock),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
    .a_gnt    (a_gnt),
    .a_rvalid (a_rvalid),
    .a_rdata  (a_rdata),
    .b_req    (b_req),
    .b_we     (b_we),
    .b_lock   (b_lock),
    .b_addr   (b_addr),
    .b_wdata  (b_wdata),
    .b_gnt    (b_gnt),
    .b_rvalid (b_rvalid),
    .b_rdata  (b_rdata),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_w_en (mem_w_en),
    .mem_rdata(mem_rdata)
  );

  // Behavioural memory: combinational read, write on the rising edge.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (!loaded) begin
      for (int k = 0; k < 256; k++) mem[k] <= (k == 5) ? 16'h0004 : 16'h0000;
      loaded <= 1'b1;
    end else if (mem_w_en) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every visible read return must match the oldest expected one on that port.
  always @(negedge clk) begin
    if (!rst && a_rvalid) begin
      checks++;
      if (a_exp.size() == 0) begin
        errors++;
        $display("FAIL a_rvalid_unexpected got 1 want 0 at %0t", $time);
      end else begin
        logic [15:0] e;
        e = a_exp.pop_front();
        if (a_rdata !== e) begin
          errors++;
          $display("FAIL a_rdata got %h want %h at %0t", a_rdata, e, $time);
        end
      end
    end
    if (!rst && b_rvalid) begin
      checks++;
      if (b_exp.size() == 0) begin
        errors++;
        $display("FAIL b_rvalid_unexpected got 1 want 0 at %0t", $time);
      end else begin
        logic [15:0] e;
        e = b_exp.pop_front();
        if (b_rdata !== e) begin
          errors++;
          $display("FAIL b_rdata got %h want %h at %0t", b_rdata, e, $time);
        end
      end
    end
  end

  task automatic set_a(input logic req, input logic we, input logic lock, input logic [7:0] addr,
                       input logic [15:0] wd);
    a_req = req; a_we = we; a_lock = lock; a_addr = addr; a_wdata = wd;
  endtask

  task automatic set_b(input logic req, input logic we, input logic lock, input logic [7:0] addr,
                       input logic [15:0] wd);
    b_req = req; b_we = we; b_lock = lock; b_addr = addr; b_wdata = wd;
  endtask

  // One clock cycle: check grants mid-cycle, then return just after the next rising edge.
  task automatic tick(input string name, input logic eag, input logic ebg, input logic ewen);
    @(negedge clk);
    chk({name, "_a_gnt"}, {15'd0, a_gnt}, {15'd0, eag});
    chk({name, "_b_gnt"}, {15'd0, b_gnt}, {15'd0, ebg});
    chk({name, "_mem_w_en"}, {15'd0, mem_w_en}, {15'd0, ewen});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    set_a(1'b1, 1'b1, 1'b0, 8'h05, 16'hAAAA);
    set_b(1'b1, 1'b1, 1'b0, 8'h05, 16'hBBBB);
    tick("reset0", 1'b0, 1'b0, 1'b0);
    tick("reset1", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    set_a(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    set_b(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    chk("reset_a_rvalid", {15'd0, a_rvalid}, 16'h0000);
    chk("reset_b_rvalid", {15'd0, b_rvalid}, 16'h0000);
    chk("reset_a_rdata", a_rdata, 16'h0000);
    chk("reset_b_rdata", b_rdata, 16'h0000);
    tick("idle0", 1'b0, 1'b0, 1'b0);

    // A read of 0x05 returns 0x0004 one cycle later.
    set_a(1'b1, 1'b0, 1'b0, 8'h05, 16'h0000);
    a_exp.push_back(16'h0004);
    @(negedge clk);
    chk("a_read_mem_addr", {8'h00, mem_addr}, 16'h0005);
    @(posedge clk);
    #1;
    set_a(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    tick("a_read_ret", 1'b0, 1'b0, 1'b0);

    // B write then read of 0x0A back to back.
    set_b(1'b1, 1'b1, 1'b0, 8'h0A, 16'hFFFC);
    tick("b_write", 1'b0, 1'b1, 1'b1);
    set_b(1'b1, 1'b0, 1'b0, 8'h0A, 16'h0000);
    b_exp.push_back(16'hFFFC);
    tick("b_read", 1'b0, 1'b1, 1'b0);
    set_b(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    tick("b_idle", 1'b0, 1'b0, 1'b0);

    // Both ports contend for 10 cycles.
    set_a(1'b1, 1'b0, 1'b0, 8'h05, 16'h0000);
    set_b(1'b1, 1'b0, 1'b0, 8'h0A, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      logic eb;
      eb = Guard && (i == 4 || i == 9);
      if (eb) b_exp.push_back(16'hFFFC);
      else    a_exp.push_back(16'h0004);
      tick($sformatf("contend%0d", i), !eb, eb, 1'b0);
    end
    set_a(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    set_b(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    tick("contend_idle", 1'b0, 1'b0, 1'b0);

    // B locks with a read of 0x00, A is held off until B unlocks with a write.
    set_b(1'b1, 1'b0, 1'b1, 8'h00, 16'h0000);
    b_exp.push_back(16'h0000);
    tick("lockb_read", 1'b0, 1'b1, 1'b0);
    set_a(1'b1, 1'b0, 1'b0, 8'h05, 16'h0000);
    set_b(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    tick("lockb_block1", 1'b0, 1'b0, 1'b0);
    set_b(1'b1, 1'b1, 1'b0, 8'h00, 16'h1234);
    tick("lockb_block2", 1'b0, 1'b1, 1'b1);
    set_b(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    a_exp.push_back(16'h0004);
    tick("lockb_release", 1'b1, 1'b0, 1'b0);
    set_a(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    set_b(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
    b_exp.push_back(16'h1234);
    tick("open_b_read", 1'b0, 1'b1, 1'b0);
    set_b(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    tick("open_idle", 1'b0, 1'b0, 1'b0);

    // A enters LOCK_A with a read; reset hits the next cycle with an A write pending.
    set_a(1'b1, 1'b0, 1'b1, 8'h05, 16'h0000);
    tick("locka_read", 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    set_a(1'b1, 1'b1, 1'b1, 8'h05, 16'hDEAD);
    tick("locka_reset", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    set_a(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    set_b(1'b1, 1'b0, 1'b0, 8'h05, 16'h0000);
    b_exp.push_back(16'h0004);
    tick("post_reset_b", 1'b0, 1'b1, 1'b0);
    set_b(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    tick("final_idle0", 1'b0, 1'b0, 1'b0);
    tick("final_idle1", 1'b0, 1'b0, 1'b0);

    chk("a_exp_drained", 16'(a_exp.size()), 16'h0000);
    chk("b_exp_drained", 16'(b_exp.size()), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
